// File: rtl/alu_issue_stage_if.sv
// Issue-stage bus: upstream decoded fields in, registered ALU operands out.
// The stage itself takes the slave view; the producer/consumer side takes master.
interface alu_issue_stage_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             funct7b5;
  logic [4:0]       rd_addr_in;
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;
  logic [WIDTH-1:0] imm_ext;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [2:0]       alu_control;
  logic [4:0]       rd_addr_out;
  logic             illegal;

  modport master (
    output in_valid, opcode, funct3, funct7b5,
    output rd_addr_in, rd1, rd2, imm_ext,
    output out_ready,
    input  in_ready, out_valid, src_a, src_b,
    input  alu_control, rd_addr_out, illegal
  );

  modport slave (
    input  in_valid, opcode, funct3, funct7b5,
    input  rd_addr_in, rd1, rd2, imm_ext,
    input  out_ready,
    output in_ready, out_valid, src_a, src_b,
    output alu_control, rd_addr_out, illegal
  );
endinterface

// File: rtl/alu_issue_stage.sv
// Registered decode/issue stage feeding the RV32I ALU.
// Resolves ALU control and B source, holds the op under back-pressure.
module alu_issue_stage #(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  alu_issue_stage_if.slave    bus,
  output logic [31:0]         stall_count
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;

  logic             is_mem;
  logic             is_br;
  logic             is_r;
  logic             is_i;
  logic [2:0]       f3_ctrl;
  logic [2:0]       ctrl_d;
  logic             imm_sel;
  logic             ill_d;
  logic             take;
  logic             stalled;

  logic             valid_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       ctrl_q;
  logic [4:0]       rd_q;
  logic             ill_q;

  assign is_mem = (bus.opcode == OP_LOAD) ||
                  (bus.opcode == OP_STORE);
  assign is_br  = (bus.opcode == OP_BR);
  assign is_r   = (bus.opcode == OP_R);
  assign is_i   = (bus.opcode == OP_I);

  // funct7b5 only selects sub for register-register ops
  always_comb begin
    f3_ctrl = 3'b000;
    case (bus.funct3)
      3'b000:  f3_ctrl = (is_r && bus.funct7b5) ? 3'b001 : 3'b000;
      3'b010:  f3_ctrl = 3'b101;
      3'b110:  f3_ctrl = 3'b011;
      3'b111:  f3_ctrl = 3'b010;
      default: f3_ctrl = 3'b000;
    endcase
  end

  always_comb begin
    ctrl_d  = 3'b000;
    imm_sel = 1'b0;
    ill_d   = 1'b0;
    unique case (1'b1)
      is_mem: imm_sel = 1'b1;
      is_br:  ctrl_d  = 3'b001;
      is_r:   ctrl_d  = f3_ctrl;
      is_i: begin
        ctrl_d  = f3_ctrl;
        imm_sel = 1'b1;
      end
      default: ill_d = 1'b1;
    endcase
  end

  assign bus.in_ready = !valid_q || bus.out_ready;
  assign take         = bus.in_valid && bus.in_ready;
  assign stalled      = valid_q && !bus.out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      ctrl_q      <= 3'b000;
      rd_q        <= 5'd0;
      ill_q       <= 1'b0;
      stall_count <= 32'd0;
    end else begin
      if (stalled)
        stall_count <= stall_count + 32'd1;
      // flush wins over both capture and consume
      if (flush) begin
        valid_q <= 1'b0;
      end else if (take) begin
        valid_q <= 1'b1;
        a_q     <= bus.rd1;
        b_q     <= imm_sel ? bus.imm_ext : bus.rd2;
        ctrl_q  <= ctrl_d;
        rd_q    <= bus.rd_addr_in;
        ill_q   <= ill_d;
      end else if (bus.out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid   = valid_q;
  assign bus.src_a       = a_q;
  assign bus.src_b       = b_q;
  assign bus.alu_control = ctrl_q;
  assign bus.rd_addr_out = rd_q;
  assign bus.illegal     = ill_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage.
// Reference model plus directed literal expectations.
module tb_alu_issue_stage;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [31:0] stall_count;

  alu_issue_stage_if #(.WIDTH(32)) bus ();

  alu_issue_stage #(.WIDTH(32)) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .bus(bus),
    .stall_count(stall_count)
  );

  int errors = 0;
  int checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference decode written as an opcode/funct3 lookup table
  function automatic void ref_decode(input logic [6:0] op,
                                     input logic [2:0] f3,
                                     input logic f7,
                                     output logic [2:0] c,
                                     output logic imm,
                                     output logic ill);
    logic [2:0] alu_f3;
    case (f3)
      3'b010:  alu_f3 = 3'd5;
      3'b110:  alu_f3 = 3'd3;
      3'b111:  alu_f3 = 3'd2;
      default: alu_f3 = 3'd0;
    endcase
    c = 3'd0; imm = 1'b0; ill = 1'b0;
    case (op)
      7'b0000011, 7'b0100011: imm = 1'b1;
      7'b1100011: c = 3'd1;
      7'b0110011: c = (f3 == 3'b000) ? (f7 ? 3'd1 : 3'd0) : alu_f3;
      7'b0010011: begin c = alu_f3; imm = 1'b1; end
      default: ill = 1'b1;
    endcase
  endfunction

  logic        m_valid = 1'b0;
  logic [31:0] m_a = '0;
  logic [31:0] m_b = '0;
  logic [2:0]  m_c = '0;
  logic [4:0]  m_rd = '0;
  logic        m_ill = 1'b0;
  logic [31:0] m_stall = '0;

  always @(posedge clk or negedge rst) begin
    logic [2:0] c;
    logic imm, ill;
    if (!rst) begin
      m_valid <= 1'b0; m_a <= '0; m_b <= '0; m_c <= '0;
      m_rd <= '0; m_ill <= 1'b0; m_stall <= '0;
    end else begin
      ref_decode(bus.opcode, bus.funct3, bus.funct7b5, c, imm, ill);
      if (m_valid && !bus.out_ready) m_stall <= m_stall + 1;
      if (flush) m_valid <= 1'b0;
      else if (bus.in_valid && (!m_valid || bus.out_ready)) begin
        m_valid <= 1'b1;
        m_a <= bus.rd1;
        m_b <= imm ? bus.imm_ext : bus.rd2;
        m_c <= c;
        m_rd <= bus.rd_addr_in;
        m_ill <= ill;
      end else if (bus.out_ready) m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
    chk("in_ready", {31'd0, bus.in_ready},
        {31'd0, (!m_valid || bus.out_ready)});
    chk("stall_count", stall_count, m_stall);
    chk("src_a", bus.src_a, m_a);
    chk("src_b", bus.src_b, m_b);
    chk("alu_control", {29'd0, bus.alu_control}, {29'd0, m_c});
    chk("rd_addr_out", {27'd0, bus.rd_addr_out}, {27'd0, m_rd});
    chk("illegal", {31'd0, bus.illegal}, {31'd0, m_ill});
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [6:0] op, input logic [2:0] f3,
                      input logic f7, input logic [4:0] rd,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] imm);
    bus.in_valid   = 1'b1;
    bus.opcode     = op;
    bus.funct3     = f3;
    bus.funct7b5   = f7;
    bus.rd_addr_in = rd;
    bus.rd1        = a;
    bus.rd2        = b;
    bus.imm_ext    = imm;
  endtask

  logic [6:0]  sw_op   [7] = '{7'b0000011, 7'b1100011, 7'b0010011,
                               7'b0010011, 7'b0010011, 7'b0010011,
                               7'b1111111};
  logic [2:0]  sw_f3   [7] = '{3'b010, 3'b000, 3'b000, 3'b010,
                               3'b110, 3'b111, 3'b000};
  logic [2:0]  sw_ctrl [7] = '{3'd0, 3'd1, 3'd0, 3'd5, 3'd3, 3'd2, 3'd0};
  logic        sw_imm  [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    bus.out_ready = 1'b1;
    send(7'b0110011, 3'b000, 1'b0, 5'd1, 32'h1, 32'h2, 32'h3);
    #1 rst = 1'b0;

    for (int i = 0; i < 3; i++) begin
      send(7'b0110011, 3'(i), i[0], 5'(i + 7), 32'hF0 + i,
           32'hE0 + i, 32'hD0 + i);
      step();
    end
    chk("rst out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst src_a", bus.src_a, 32'd0);
    chk("rst stall", stall_count, 32'd0);

    rst = 1'b1;
    send(7'b0110011, 3'b000, 1'b1, 5'd4, 32'd10, 32'd3, 32'd99);
    step();
    chk("sub valid", {31'd0, bus.out_valid}, 32'd1);
    chk("sub ctrl", {29'd0, bus.alu_control}, 32'd1);
    chk("sub a", bus.src_a, 32'd10);
    chk("sub b", bus.src_b, 32'd3);

    for (int i = 0; i < 7; i++) begin
      send(sw_op[i], sw_f3[i], 1'b1, 5'(i), 32'h100 + i,
           32'h200 + i, 32'h10 + i);
      step();
      chk("sweep ctrl", {29'd0, bus.alu_control}, {29'd0, sw_ctrl[i]});
      chk("sweep b", bus.src_b, sw_imm[i] ? 32'h10 + i : 32'h200 + i);
      chk("sweep ill", {31'd0, bus.illegal}, (i == 6) ? 32'd1 : 32'd0);
    end

    bus.in_valid = 1'b0;
    step();
    send(7'b0010011, 3'b110, 1'b0, 5'd9, 32'hAAAA0001, 32'd0, 32'h5);
    bus.out_ready = 1'b0;
    step();
    send(7'b0110011, 3'b111, 1'b0, 5'd10, 32'hBBBB0002, 32'd7, 32'd0);
    repeat (4) step();
    chk("bp frozen a", bus.src_a, 32'hAAAA0001);
    chk("bp frozen b", bus.src_b, 32'h5);
    chk("bp in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("bp stall", stall_count, 32'd4);
    bus.out_ready = 1'b1;
    step();
    chk("bp next a", bus.src_a, 32'hBBBB0002);
    chk("bp next ctrl", {29'd0, bus.alu_control}, 32'd2);
    bus.in_valid = 1'b0;
    step();

    for (int i = 0; i < 8; i++) begin
      send(7'b0110011, 3'b000, 1'b0, 5'(i), 32'h300 + i, 32'h1, 32'h0);
      step();
      chk("b2b valid", {31'd0, bus.out_valid}, 32'd1);
      chk("b2b a", bus.src_a, 32'h300 + i);
    end
    bus.in_valid = 1'b0;
    step();

    send(7'b0110011, 3'b000, 1'b0, 5'd3, 32'hCAFE0000, 32'h1, 32'h0);
    bus.out_ready = 1'b0;
    step();
    send(7'b0110011, 3'b000, 1'b0, 5'd4, 32'hDEAD0000, 32'h2, 32'h0);
    flush = 1'b1;
    step();
    chk("flush valid", {31'd0, bus.out_valid}, 32'd0);
    chk("flush hold a", bus.src_a, 32'hCAFE0000);
    chk("flush stall", stall_count, 32'd5);
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    step();
    flush = 1'b1;
    step();
    chk("idle flush valid", {31'd0, bus.out_valid}, 32'd0);
    flush = 1'b0;

    send(7'b0010011, 3'b000, 1'b0, 5'd6, 32'h55, 32'h0, 32'h1);
    bus.out_ready = 1'b0;
    step();
    bus.in_valid = 1'b0;
    step();
    chk("pre-rst valid", {31'd0, bus.out_valid}, 32'd1);
    chk("pre-rst stall", stall_count, 32'd6);
    rst = 1'b0;
    #1;
    chk("async valid", {31'd0, bus.out_valid}, 32'd0);
    chk("async stall", stall_count, 32'd0);
    chk("async in_ready", {31'd0, bus.in_ready}, 32'd1);
    #1 rst = 1'b1;
    bus.out_ready = 1'b1;
    repeat (2) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Registered decode/issue stage directly upstream of the RV32I ALU. Accepts decoded instruction fields and register-file read data, resolves the 3-bit ALU control code and the B-operand source (register or immediate), and presents registered `src_a` / `src_b` / `alu_control` to the ALU through a valid/ready handshake. Supports back-pressure, flush, and a stall-cycle counter for debug.

## Interface
- `WIDTH`, 32: operand width.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  reset; asynchronous, active-low. One clock, no other clock domains.
- `in_valid`  input  1  upstream fields valid.
- `in_ready`  output  1  stage can accept this cycle.
- `opcode`  input  7  instruction[6:0].
- `funct3`  input  3  instruction[14:12].
- `funct7b5`  input  1  instruction[30].
- `rd_addr_in`  input  5  destination register.
- `rd1`  input  WIDTH  register-file port 1 data.
- `rd2`  input  WIDTH  register-file port 2 data.
- `imm_ext`  input  WIDTH  sign-extended immediate.
- `flush`  input  1  kill held and incoming op.
- `out_valid`  output  1  registered op valid.
- `out_ready`  input  1  ALU side consumes.
- `src_a`  output  WIDTH  registered A operand (= `rd1`).
- `src_b`  output  WIDTH  registered B operand.
- `alu_control`  output  3  registered ALU control code.
- `rd_addr_out`  output  5  registered destination.
- `illegal`  output  1  registered: opcode not in supported set.
- `stall_count`  output  32  cycles with `out_valid && !out_ready`.

## Operation
- Opcode classes:
  - load `0000011`, store `0100011`: B = `imm_ext`, control 000 (add).
  - branch `1100011`: B = `rd2`, control 001 (sub).
  - R-type `0110011`: B = `rd2`.
  - I-ALU `0010011`: B = `imm_ext`.
- R/I funct3 decode:
  - 000: 001 if R-type and `funct7b5`, else 000. I-type `addi` is never sub, regardless of `funct7b5`.
  - 010: 101 (slt).
  - 110: 011 (or).
  - 111: 010 (and).
  - Any other funct3: 000.
- Any other opcode: control 000, B = `rd2`, `illegal` = 1. The op still flows; `illegal` is advisory.
- `in_ready = !out_valid || out_ready`, combinational.
- Capture when `in_valid && in_ready`. All output data registers load together and `out_valid` sets to 1.
- When `out_valid && out_ready` with no new capture, `out_valid` clears to 0. Data registers hold their last value.
- `flush`: at the next edge `out_valid` = 0 and the incoming op is not captured, even if `in_valid && in_ready`. Flush has priority over capture and over consume.
- `stall_count`:
  - Increments by 1 on each edge where `out_valid && !out_ready`, sampled before the edge.
  - Wraps from 0xFFFFFFFF to 0.
  - Unaffected by `flush`.

## Timing
- Latency: 1 cycle from capture edge to `out_valid`.
- Throughput: 1 op/cycle when `out_ready` is held high.
- Registered outputs do not change while `out_valid && !out_ready` (stable under back-pressure).
- Simultaneous consume and capture in the same cycle: new op replaces old, `out_valid` stays 1, no bubble.
- Reset asserted (rst = 0), asynchronously:
  - `out_valid` = 0, `src_a` = `src_b` = 0, `alu_control` = 000, `rd_addr_out` = 0, `illegal` = 0, `stall_count` = 0.
  - `in_ready` therefore reads 1 during reset.
- Reset mid-operation: the held op is discarded immediately, with no edge required.
- Reset release: first capture is possible at the first rising edge after `rst` goes high.
- Inputs are sampled only at rising edges. The data path is purely combinational decode into registers.

## Test plan
- **Reset:** hold rst = 0 with inputs toggling → all outputs zero, `in_ready` = 1. Release, then present an R-type `sub` (`funct7b5` = 1, funct3 000, rd1 = 10, rd2 = 3) → next cycle `out_valid` = 1, `alu_control` = 001, `src_a` = 10, `src_b` = 3.
- **Decode sweep:** per-cycle stream of lw (imm 0x10), beq, addi with `funct7b5` = 1, slti, ori, andi, opcode `1111111`, with `out_ready` = 1 → controls 000, 001, 000, 101, 011, 010, 000. B = imm for lw/addi/slti/ori/andi and rd2 for beq and the illegal op; `illegal` = 1 only on the last op.
- **Back-pressure:** capture an op, then hold `out_ready` = 0 for 4 cycles while `in_valid` = 1 with new data → outputs frozen, `in_ready` = 0, `stall_count` = 4. Raise `out_ready` → next op appears one cycle later.
- **Back-to-back:** consume and capture in the same cycle for 8 consecutive cycles → `out_valid` continuously 1, each op visible exactly one cycle.
- **Flush:** `flush` together with `in_valid` while an op is held → `out_valid` = 0 next cycle and the incoming op is lost. Assert `flush` with `out_valid` = 0 → no effect.
- **Async reset mid-stall:** pulse rst low between edges while `out_valid` = 1 → `out_valid` drops without a clock edge; `stall_count` = 0.
